// File: rtl/channel_dump_if.sv
// Host/RAM/UART-side signal bundle of channel_dump_ctrl.
// The controller connects through the master modport and the environment through slave.
interface channel_dump_if #(
  parameter int LOG2 = 9
);
  logic            dump_req;
  logic [2:0]      dump_ch;
  logic            abort;
  logic            capture_done;
  logic            read_done;
  logic [7:0]      rdata;
  logic            tx_done;
  logic            start_rd;
  logic [2:0]      ch_sel;
  logic [7:0]      tx_data;
  logic            trmt;
  logic            busy;
  logic            dump_done;
  logic            err;
  logic [LOG2:0]   byte_cnt;

  modport master (
    input  dump_req, dump_ch, abort, capture_done, read_done, rdata, tx_done,
    output start_rd, ch_sel, tx_data, trmt, busy, dump_done, err, byte_cnt
  );

  modport slave (
    output dump_req, dump_ch, abort, capture_done, read_done, rdata, tx_done,
    input  start_rd, ch_sel, tx_data, trmt, busy, dump_done, err, byte_cnt
  );
endinterface

// File: rtl/channel_dump_ctrl.sv
// Capture-RAM readout sequencer: reads one sample per start_rd and ships it over the UART handshake.
// Define CHANNEL_DUMP_HDR_EN to prefix each dump with header byte {5'b10100, ch_sel}.
//
// state      | meaning
// IDLE       | waiting for dump_req
// HDR        | header strobe (CHANNEL_DUMP_HDR_EN only)
// HDR_WAIT   | header in flight (CHANNEL_DUMP_HDR_EN only)
// RD_REQ     | start_rd pulse; read_done ends the dump
// RAM_WAIT   | RD_LAT-cycle read latency countdown
// XMIT       | trmt pulse for the sampled byte
// TX_WAIT    | byte in flight, wait for tx_done
// DONE       | completion / runaway report, back to IDLE
module channel_dump_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9,
  parameter int RD_LAT  = 1,
  parameter int NUM_CH  = 5
) (
  input  logic          clk,
  input  logic          rst,
  channel_dump_if.master bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
`ifdef CHANNEL_DUMP_HDR_EN
  localparam logic [2:0] S_HDR      = 3'd1;
  localparam logic [2:0] S_HDR_WAIT = 3'd2;
`endif
  localparam logic [2:0] S_RD_REQ   = 3'd3;
  localparam logic [2:0] S_RAM_WAIT = 3'd4;
  localparam logic [2:0] S_XMIT     = 3'd5;
  localparam logic [2:0] S_TX_WAIT  = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  localparam logic [2:0]      MAX_CH    = 3'(NUM_CH);
  localparam logic [1:0]      LAT_INIT  = 2'(RD_LAT - 1);
  localparam logic [LOG2:0]   CNT_MAX   = '1;
  localparam logic [LOG2+1:0] ENTRIES_W = (LOG2+2)'(ENTRIES);

  logic [2:0]      state;
  logic [1:0]      lat_cnt;
  logic            runaway;
  logic [2:0]      ch_sel;
  logic [7:0]      tx_data;
  logic            busy;
  logic            dump_done;
  logic            err;
  logic [LOG2:0]   byte_cnt;
  logic [LOG2+1:0] cnt_next;
  logic            req_ok;
  logic            halt;

  assign req_ok   = bus.capture_done && (bus.dump_ch != 3'd0) && (bus.dump_ch <= MAX_CH);
  assign cnt_next = {1'b0, byte_cnt} + (LOG2+2)'(1);
  // abort or reset this cycle suppresses both strobes
  assign halt     = rst || bus.abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      lat_cnt   <= '0;
      runaway   <= 1'b0;
      ch_sel    <= '0;
      tx_data   <= '0;
      busy      <= 1'b0;
      dump_done <= 1'b0;
      err       <= 1'b0;
      byte_cnt  <= '0;
    end else begin
      dump_done <= 1'b0;
      err       <= 1'b0;
      if (state != S_IDLE && bus.abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.dump_req) begin
              if (req_ok) begin
                ch_sel   <= bus.dump_ch;
                byte_cnt <= '0;
                busy     <= 1'b1;
                runaway  <= 1'b0;
`ifdef CHANNEL_DUMP_HDR_EN
                tx_data  <= {5'b10100, bus.dump_ch};
                state    <= S_HDR;
`else
                state    <= S_RD_REQ;
`endif
              end else begin
                err <= 1'b1;
              end
            end
          end
`ifdef CHANNEL_DUMP_HDR_EN
          S_HDR:      state <= S_HDR_WAIT;
          S_HDR_WAIT: if (bus.tx_done) state <= S_RD_REQ;
`endif
          S_RD_REQ: begin
            if (bus.read_done) begin
              state <= S_DONE;
            end else begin
              lat_cnt <= LAT_INIT;
              state   <= S_RAM_WAIT;
            end
          end
          S_RAM_WAIT: begin
            if (lat_cnt == 2'd0) begin
              tx_data <= bus.rdata;
              state   <= S_XMIT;
            end else begin
              lat_cnt <= lat_cnt - 2'd1;
            end
          end
          S_XMIT: state <= S_TX_WAIT;
          S_TX_WAIT: begin
            if (bus.tx_done) begin
              if (byte_cnt != CNT_MAX) byte_cnt <= byte_cnt + (LOG2+1)'(1);
              // hitting the capture depth without read_done means channel_capture lost track
              if (cnt_next == ENTRIES_W) begin
                runaway <= 1'b1;
                err     <= 1'b1;
                state   <= S_DONE;
              end else begin
                state <= S_RD_REQ;
              end
            end
          end
          S_DONE: begin
            dump_done <= !runaway;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.start_rd  = (state == S_RD_REQ) && !halt;
`ifdef CHANNEL_DUMP_HDR_EN
  assign bus.trmt      = ((state == S_XMIT) || (state == S_HDR)) && !halt;
`else
  assign bus.trmt      = (state == S_XMIT) && !halt;
`endif
  assign bus.ch_sel    = ch_sel;
  assign bus.tx_data   = tx_data;
  assign bus.busy      = busy;
  assign bus.dump_done = dump_done;
  assign bus.err       = err;
  assign bus.byte_cnt  = byte_cnt;

endmodule
